lzd_norm_seq: RTL and testbench



---
 rtl/lzd_norm_seq_pkg.sv | 32 +++
 rtl/lzd_12bits.sv | 38 +++
 rtl/lzd_norm_seq.sv | 166 ++++++++++++++++
 tb/tb_lzd_norm_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lzd_norm_seq_pkg.sv
// -----------------------------------------------------------------------------
// lzd_norm_seq_pkg
// Shared constants for the sequential leading-zero normalizer:
//   CHUNK_W  - bits examined per scan cycle (width of the lzd_12bits input)
//   LZD_PW   - width of the lzd_12bits position output
//   state_t  - FSM state vector type and its encodings
//   idx_width() - width of a chunk index register, never narrower than 1 bit
// -----------------------------------------------------------------------------
package lzd_norm_seq_pkg;

    localparam int CHUNK_W = 12;
    localparam int LZD_PW  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A single-chunk operand still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lzd_12bits.sv
// -----------------------------------------------------------------------------
// lzd_12bits
// Combinational 12-bit leading-zero detector.
// Ports:
//   src - 12-bit chunk, src[11] is the most significant bit
//   p   - number of leading zeros counted from src[11], 0..11 (meaningful only
//         when v = 1)
//   v   - at least one bit of src is set
// -----------------------------------------------------------------------------
module lzd_12bits (
    input  logic [11:0] src,
    output logic [3:0]  p,
    output logic        v
);

    assign v = |src;

    // Priority encode the first set bit from the MSB.
    always_comb begin
        p = 4'd0;
        casez (src)
            12'b1???????????: p = 4'd0;
            12'b01??????????: p = 4'd1;
            12'b001?????????: p = 4'd2;
            12'b0001????????: p = 4'd3;
            12'b00001???????: p = 4'd4;
            12'b000001??????: p = 4'd5;
            12'b0000001?????: p = 4'd6;
            12'b00000001????: p = 4'd7;
            12'b000000001???: p = 4'd8;
            12'b0000000001??: p = 4'd9;
            12'b00000000001?: p = 4'd10;
            12'b000000000001: p = 4'd11;
            default:          p = 4'd0;
        endcase
    end

endmodule

// File: rtl/lzd_norm_seq.sv
// -----------------------------------------------------------------------------
// lzd_norm_seq
// Multi-cycle normalizer: scans a W-bit operand MSB-first, one 12-bit chunk
// per cycle through a single shared lzd_12bits, and returns the leading-zero
// count together with the operand shifted so that its MSB is 1.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - operand offered            in_ready  - operand can be accepted
//   in_data   - W-bit operand
//   out_valid - result held                out_ready - consumer takes result
//   out_cnt   - leading-zero count, 0..W
//   out_norm  - in_data << out_cnt, truncated to W bits
//   out_zero  - operand was all zeros
// W must be a multiple of 12 and at least 12.
// -----------------------------------------------------------------------------
module lzd_norm_seq
    import lzd_norm_seq_pkg::*;
#(
    parameter  int W  = 48,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_cnt,
    output logic [W-1:0]  out_norm,
    output logic          out_zero
);

    localparam int NCHUNK = W / CHUNK_W;
    localparam int IDXW   = idx_width(NCHUNK);

    state_t              state_q, state_d;
    logic [W-1:0]        opnd_q, opnd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                zero_q, zero_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [CHUNK_W-1:0]  lzd_src_s;
    logic [LZD_PW-1:0]   lzd_p_s;
    logic                lzd_v_s;
    logic [W-1:0]        opnd_shl_p_s;

    // The top chunk of the working register is always the one under test;
    // the register is shifted left as chunks are consumed.
    assign lzd_src_s = opnd_q[W-1 -: CHUNK_W];

    lzd_12bits u_lzd (
        .src (lzd_src_s),
        .p   (lzd_p_s),
        .v   (lzd_v_s)
    );

    // Final alignment: 12-way mux of constant left shifts selected by p.
    always_comb begin
        opnd_shl_p_s = opnd_q;
        case (lzd_p_s)
            4'd0:    opnd_shl_p_s = opnd_q;
            4'd1:    opnd_shl_p_s = opnd_q << 1;
            4'd2:    opnd_shl_p_s = opnd_q << 2;
            4'd3:    opnd_shl_p_s = opnd_q << 3;
            4'd4:    opnd_shl_p_s = opnd_q << 4;
            4'd5:    opnd_shl_p_s = opnd_q << 5;
            4'd6:    opnd_shl_p_s = opnd_q << 6;
            4'd7:    opnd_shl_p_s = opnd_q << 7;
            4'd8:    opnd_shl_p_s = opnd_q << 8;
            4'd9:    opnd_shl_p_s = opnd_q << 9;
            4'd10:   opnd_shl_p_s = opnd_q << 10;
            4'd11:   opnd_shl_p_s = opnd_q << 11;
            default: opnd_shl_p_s = opnd_q;
        endcase
    end

    // FSM next-state and datapath next-values.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (lzd_v_s) begin
                    opnd_d  = opnd_shl_p_s;
                    cnt_d   = cnt_q + CW'(lzd_p_s);
                    zero_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (idx_q != IDXW'(NCHUNK - 1)) begin
                    // Whole chunk is zero: drop it and count all 12 bits.
                    opnd_d  = opnd_q << CHUNK_W;
                    cnt_d   = cnt_q + CW'(CHUNK_W);
                    idx_d   = idx_q + IDXW'(1);
                    state_d = ST_SCAN;
                end else begin
                    // Last chunk also zero: report the saturated count directly.
                    opnd_d  = '0;
                    cnt_d   = CW'(W);
                    zero_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered copies of the next-state decode so the
    // outputs come straight from flops.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opnd_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_cnt   = cnt_q;
    assign out_norm  = opnd_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzd_norm_seq.sv
// -----------------------------------------------------------------------------
// tb_lzd_norm_seq
// Directed bench for lzd_norm_seq (W = 48). Expected values are hand-computed.
// Latency is counted in rising edges with the accepting edge numbered 1, so a
// result from chunk k shows up after edge k+2 and an all-zero result after
// edge NCHUNK+1 = 5.
// -----------------------------------------------------------------------------
module tb_lzd_norm_seq;

    localparam int W  = 48;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cnt;
    logic [W-1:0]  out_norm;
    logic          out_zero;

    int n_checks;
    int n_fail;

    lzd_norm_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_norm  (out_norm),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, measure latency, check the result, then drain it.
    task automatic run_op(input string tag, input logic [W-1:0] data,
                          input int exp_cnt, input logic [W-1:0] exp_norm,
                          input logic exp_zero, input int exp_edges);
        int edges;
        check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        edges    = 1;
        in_valid = 1'b0;
        in_data  = '0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_eq({tag, "_lat"},  64'(edges),    64'(exp_edges));
        check_eq({tag, "_cnt"},  64'(out_cnt),  64'(exp_cnt));
        check_eq({tag, "_norm"}, 64'(out_norm), 64'(exp_norm));
        check_eq({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int edges;
        int seen;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset / idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_cnt",   64'(out_cnt),   64'd0);
        check_eq("rst_out_norm",  64'(out_norm),  64'd0);
        check_eq("rst_out_zero",  64'(out_zero),  64'd0);

        // Directed vectors: tag, data, cnt, norm, zero, latency
        run_op("msb",   48'h8000_0000_0001, 0,  48'h8000_0000_0001, 1'b0, 2);
        run_op("mid",   48'h0000_0003_0000, 30, 48'hC000_0000_0000, 1'b0, 4);
        run_op("zero",  48'h0000_0000_0000, 48, 48'h0000_0000_0000, 1'b1, 5);
        run_op("lsb",   48'h0000_0000_0001, 47, 48'h8000_0000_0000, 1'b0, 5);
        run_op("chk1",  48'h0000_0800_0000, 20, 48'h8000_0000_0000, 1'b0, 3);
        run_op("pat",   48'h0123_4567_89AB, 7,  48'h91A2_B3C4_D580, 1'b0, 2);
        run_op("p11",   48'h0010_0000_0000, 11, 48'h8000_0000_0000, 1'b0, 2);
        run_op("c1msb", 48'h0008_0000_0000, 12, 48'h8000_0000_0000, 1'b0, 3);

        // Backpressure: hold DONE for 10 cycles while a new operand is offered.
        in_valid = 1'b1;
        in_data  = 48'h0000_0003_0000;
        tick();
        in_data  = 48'h0000_0000_0001;
        edges    = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_eq("bp_lat", 64'(edges), 64'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_ready", 64'(in_ready),  64'd0);
            check_eq("bp_cnt",   64'(out_cnt),   64'd30);
            check_eq("bp_norm",  64'(out_norm),  64'(48'hC000_0000_0000));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_idle_ready", 64'(in_ready),  64'd1);
        check_eq("bp_idle_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check_eq("b2b_accepted", 64'(in_ready), 64'd0);
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_eq("b2b_lat",  64'(edges),    64'd5);
        check_eq("b2b_cnt",  64'(out_cnt),  64'd47);
        check_eq("b2b_norm", 64'(out_norm), 64'(48'h8000_0000_0000));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset on the second SCAN cycle discards the operation.
        in_valid = 1'b1;
        in_data  = 48'h0000_0000_0001;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rscan_ready", 64'(in_ready),  64'd1);
        check_eq("rscan_valid", 64'(out_valid), 64'd0);
        check_eq("rscan_cnt",   64'(out_cnt),   64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) begin
                seen++;
            end else begin
                seen = seen;
            end
        end
        check_eq("rscan_no_out", 64'(seen), 64'd0);

        // Reset together with in_valid: nothing accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 48'h8000_0000_0000;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        check_eq("rvalid_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid || !in_ready) begin
                seen++;
            end else begin
                seen = seen;
            end
        end
        check_eq("rvalid_none", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
